// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a shared 7-segment decoder: cycles
// through NUM_DIGITS stored codes with a blanking gap before every digit.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [2:0]            load_idx,
  input  logic [4:0]            load_code,
  output logic [4:0]            code,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] SHOW_PEN   = CNT_W'(REFRESH_DIV - 2);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_ONE = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       store [NUM_DIGITS];

  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] next_idx;

  assign wr_ok    = load && (int'(load_idx) < NUM_DIGITS);
  assign wr_idx   = load_idx[IDX_W-1:0];
  assign next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  // NOTE: the stored codes must read back as zero after reset, so this small
  // register file is reset explicitly rather than left to power-up contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) store[i] <= '0;
    end else if (wr_ok) begin
      store[wr_idx] <= load_code;
    end
  end

  // NOTE: non-blocking assignments make the BLANK-entry capture see the code
  // stored before a same-edge write, so a colliding load appears a frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      code       <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      code       <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= BLANK;
          idx        <= '0;
          cnt        <= '0;
          code       <= store[0];
          digit_en   <= '0;
          frame_done <= 1'b0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state      <= SHOW;
            cnt        <= '0;
            digit_en   <= EN_ONE << idx;
            // With a one-cycle SHOW the first SHOW cycle is also the last.
            frame_done <= (REFRESH_DIV == 1) && (idx == LAST_IDX);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state      <= BLANK;
            idx        <= next_idx;
            cnt        <= '0;
            code       <= store[next_idx];
            digit_en   <= '0;
            frame_done <= 1'b0;
          end else begin
            cnt        <= cnt + 1'b1;
            frame_done <= (REFRESH_DIV > 1) && (idx == LAST_IDX) && (cnt == SHOW_PEN);
          end
        end
        default: begin
          state      <= IDLE;
          idx        <= '0;
          cnt        <= '0;
          code       <= '0;
          digit_en   <= '0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a timeline model predicts each
// cycle's outputs; a negedge monitor pops and compares them.
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int R  = 3;
  localparam int B  = 1;
  localparam int DP = B + R;

  typedef struct packed {
    logic [4:0]   code;
    logic [N-1:0] en;
    logic         fd;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [2:0]   load_idx = '0;
  logic [4:0]   load_code = '0;
  logic [4:0]   code;
  logic [N-1:0] digit_en;
  logic         frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb[$];

  // Reference model: time since scan start plus a snapshot of the code.
  bit         m_run = 1'b0;
  int         m_t = 0;
  logic [4:0] m_code = '0;
  logic [4:0] m_store [N];

  bit track = 1'b0;
  bit seen_fd = 1'b0;
  int since_fd = 0;
  int on_cnt [N];

  display_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .load_idx  (load_idx),
    .load_code (load_code),
    .code      (code),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int cur_digit();
    return (m_t / DP) % N;
  endfunction

  function automatic bit in_show();
    return (m_t % DP) >= B;
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_t    = 0;
    m_code = '0;
    for (int i = 0; i < N; i++) m_store[i] = '0;
  endtask

  // Called right after a rising edge with the inputs that edge sampled.
  task automatic model_tick();
    exp_t e;
    if (!enable) begin
      m_run  = 1'b0;
      m_code = '0;
    end else if (!m_run) begin
      m_run  = 1'b1;
      m_t    = 0;
      m_code = m_store[0];
    end else begin
      m_t++;
      if (m_t % DP == 0) m_code = m_store[cur_digit()];
    end
    if (load && int'(load_idx) < N) m_store[load_idx] = load_code;
    e.code = m_code;
    e.en   = (m_run && in_show()) ? N'(1) << cur_digit() : '0;
    e.fd   = m_run && (cur_digit() == N - 1) && (m_t % DP == DP - 1);
    sb.push_back(e);
  endtask

  task automatic step(input logic en, input logic ld, input logic [2:0] idx,
                      input logic [4:0] cd);
    enable    = en;
    load      = ld;
    load_idx  = idx;
    load_code = cd;
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b1, 1'b0, 3'd0, 5'd0);
  endtask

  task automatic advance_to(input int digit, input bit show);
    for (int k = 0; k < 4 * N * DP; k++) begin
      if (m_run && cur_digit() == digit && in_show() == show) return;
      step(1'b1, 1'b0, 3'd0, 5'd0);
    end
    check("advance_to_timeout", 0, 1);
  endtask

  // Monitor: compares each presented cycle against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("code", int'(code), int'(e.code));
      check("digit_en", int'(digit_en), int'(e.en));
      check("frame_done", int'(frame_done), int'(e.fd));
      check("onehot0", int'($onehot0(digit_en)), 1);
    end
    if (track) begin
      since_fd++;
      for (int i = 0; i < N; i++) if (digit_en[i]) on_cnt[i]++;
      if (frame_done) begin
        if (seen_fd) begin
          check("fd_period", since_fd, N * DP);
          for (int i = 0; i < N; i++) check("en_cycles_per_frame", on_cnt[i], R);
        end
        seen_fd  = 1'b1;
        since_fd = 0;
        for (int i = 0; i < N; i++) on_cnt[i] = 0;
      end
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) on_cnt[i] = 0;

    // Power-on reset.
    #1 rst_n = 1'b0;
    #2;
    check("rst_code", int'(code), 0);
    check("rst_digit_en", int'(digit_en), 0);
    check("rst_frame_done", int'(frame_done), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'd0, 5'd0);

    // Basic scan with four known codes, two full frames.
    step(1'b0, 1'b1, 3'd0, 5'b10111);
    step(1'b0, 1'b1, 3'd1, 5'b11010);
    step(1'b0, 1'b1, 3'd2, 5'b01001);
    step(1'b0, 1'b1, 3'd3, 5'b00010);
    run(2 * N * DP + 1);

    // Write the digit currently on display; it must wait for its next BLANK.
    advance_to(2, 1'b1);
    step(1'b1, 1'b1, 3'd2, 5'b11111);
    run(2 * N * DP);

    // Out-of-range index must leave every stored code alone.
    step(1'b1, 1'b1, 3'd5, 5'b11110);
    run(N * DP + 2);

    // Drop enable during digit 1 SHOW, then restart from digit 0.
    advance_to(1, 1'b1);
    step(1'b0, 1'b0, 3'd0, 5'd0);
    step(1'b0, 1'b0, 3'd0, 5'd0);
    run(N * DP + 4);

    // Asynchronous reset mid-scan clears outputs and stored codes.
    advance_to(3, 1'b1);
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_code", int'(code), 0);
    check("midrst_digit_en", int'(digit_en), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 1'b0, 3'd0, 5'd0);
    step(1'b0, 1'b0, 3'd0, 5'd0);
    run(N * DP + 2);

    // Ten-plus frames of random loads with frame-level accounting.
    track = 1'b1;
    for (int k = 0; k < 11 * N * DP; k++) begin
      if ($urandom_range(2) == 0)
        step(1'b1, 1'b1, 3'($urandom_range(7)), 5'($urandom));
      else
        step(1'b1, 1'b0, 3'd0, 5'd0);
    end
    @(negedge clk);
    track = 1'b0;
    #1;
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
